async_event_arbiter: RTL and testbench
======================================

ASYNC_EVENT_ARBITER -- requirements
Module: async_event_arbiter

Interface
REQ-001 Parameter N, default 4, is the number of asynchronous event inputs; legal range 2..8.
REQ-002 Parameter ID_W, default 2, is the width of evt_id; N SHALL NOT exceed 2**ID_W.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  is the reset: synchronous, active-high.
REQ-005 async_in  input  N  carries level event lines from outside the clk domain; bit i is channel i.
REQ-006 evt_ready  input  1  is the consumer ready signal; it accepts the offered event.
REQ-007 ovf_clr  input  1  is a single-cycle pulse that clears all overflow flags.
REQ-008 evt_valid  output  1  is registered, high while an event is offered.
REQ-009 evt_id  output  ID_W  is registered, the channel index of the offered event.
REQ-010 ovf  output  N  is registered; bit i is a sticky overflow flag for channel i.

Function
REQ-011 Each async_in bit SHALL pass through two synchronizer flops (s1, s2) plus one history flop (s3); no other logic SHALL read async_in.
REQ-012 A rising edge on channel i SHALL be detected when s2[i]=1 and s3[i]=0, and SHALL set pend[i] on that clock edge.
REQ-013 A falling edge, or a level held high, SHALL NOT generate further events.
REQ-014 If a rising edge is detected while pend[i]=1, pend[i] SHALL stay 1 and ovf[i] SHALL be set; the extra event is dropped.
REQ-015 The FSM SHALL have two states: IDLE (evt_valid=0) and OFFER (evt_valid=1).
REQ-016 In IDLE with any pend bit set, the FSM SHALL go to OFFER on the next edge, load evt_id with the winner and clear the winner's pend bit.
REQ-017 The winner SHALL be the first set pend bit searching upward from (last_id+1) mod N, wrapping around; last_id resets to N-1, so channel 0 has first priority after reset.
REQ-018 In OFFER, evt_valid and evt_id SHALL hold stable until evt_ready is sampled high.
REQ-019 On a transfer (OFFER and evt_ready=1), last_id SHALL take evt_id.
REQ-019a On a transfer, if any pend bit is set, the FSM SHALL stay in OFFER with the next winner, arbitrated against the updated last_id, giving back-to-back transfers at one per cycle.
REQ-019b On a transfer with no pend bit set, the FSM SHALL return to IDLE.
REQ-020 If a pend bit is cleared by a grant while a new edge is detected on the same channel on the same edge, pend SHALL end at 1 and ovf SHALL NOT be set.
REQ-021 End-to-end latency: after async_in[i] rises and is captured by s1 at edge E1, pend[i] SHALL be set at E3 and evt_valid SHALL rise at E4 (with the FSM idle and the channel uncontended).
REQ-022 ovf_clr SHALL clear all ovf bits on the next edge; a simultaneous new overflow on bit i SHALL win, leaving ovf[i]=1.

Reset
REQ-023 While rst is high: s1, s2, s3, pend, ovf and evt_valid SHALL be 0; evt_id SHALL be 0; last_id SHALL be N-1; state SHALL be IDLE.
REQ-024 Edge detection SHALL be masked for the first 3 edges after rst is sampled low, driven by a 2-bit prime counter, so an input held high across reset generates no event.
REQ-025 If rst asserts in OFFER, the pending offer and all pend bits SHALL be discarded with no transfer.

Verification
REQ-026 async_in[0] 0->1 between edges, evt_ready=1 -> evt_valid=1, evt_id=0 exactly at E4, for one cycle only.
REQ-027 async_in=4'b1111 rising together, evt_ready=1 -> four consecutive valid cycles with evt_id 0,1,2,3, then evt_valid=0.
REQ-028 evt_ready=0 with channel 2 pending, then two more rising edges on channel 2 -> evt_id=2 held stable and ovf[2]=1; one ovf_clr pulse -> ovf=0.
REQ-029 async_in[1]=1 held through reset and released -> evt_valid stays 0 for at least 20 cycles.
REQ-030 After channel 3 is granted, channels 0 and 3 pending -> channel 0 is granted first (round-robin wrap).
REQ-031 rst pulse of 1 cycle during OFFER with evt_id=1 -> next cycle evt_valid=0, pend=0, ovf=0.

Source files
------------

// File: rtl/async_event_arbiter.sv
// Synchronizes N asynchronous level event lines, detects rising edges into sticky
// pending bits and offers them one at a time to a consumer with round-robin priority.
module async_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    async_in,
    input  logic            evt_ready,
    input  logic            ovf_clr,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    output logic [N-1:0]    ovf
);

    localparam int CW = ID_W + 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    s1_r;
    logic [N-1:0]    s2_r;
    logic [N-1:0]    s3_r;
    logic [N-1:0]    pend_r;
    logic [N-1:0]    ovf_r;
    logic [1:0]      prime_r;
    logic [ID_W-1:0] last_id_r;
    logic [ID_W-1:0] evt_id_r;
    logic            evt_valid_r;

    logic            primed_s;
    logic [N-1:0]    rise_s;
    logic [N-1:0]    grant_mask_s;
    logic [N-1:0]    pend_s;
    logic [N-1:0]    ovf_set_s;
    logic [N-1:0]    ovf_s;
    logic [ID_W-1:0] base_s;
    logic [ID_W-1:0] win_id_s;
    logic [ID_W-1:0] evt_id_s;
    logic [ID_W-1:0] last_id_s;
    logic [1:0]      prime_s;
    logic            win_found_s;
    logic            load_s;
    logic            xfer_s;

    // Edge detection is masked until the synchronizer chain has refilled after reset.
    always_comb begin
        primed_s = (prime_r == 2'd3);
        if (primed_s) begin
            prime_s = prime_r;
        end else begin
            prime_s = prime_r + 2'd1;
        end
        rise_s = s2_r & ~s3_r & {N{primed_s}};
    end

    // Round-robin search: lowest offset above base wins, so scan offsets downward and overwrite.
    always_comb begin
        logic [CW-1:0] cand;
        win_found_s = 1'b0;
        win_id_s    = '0;
        cand        = '0;
        if (state_r == OFFER) begin
            base_s = evt_id_r;
        end else begin
            base_s = last_id_r;
        end
        for (int i = N - 1; i >= 0; i--) begin
            cand = CW'(base_s) + CW'(i) + CW'(1);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end else begin
                cand = cand;
            end
            if (pend_r[cand[ID_W-1:0]]) begin
                win_found_s = 1'b1;
                win_id_s    = cand[ID_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Offer FSM next state plus grant, pending and overflow updates.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        xfer_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_s = OFFER;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    xfer_s = 1'b1;
                    if (win_found_s) begin
                        state_s = OFFER;
                        load_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = OFFER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (load_s) begin
            grant_mask_s = {{(N-1){1'b0}}, 1'b1} << win_id_s;
            evt_id_s     = win_id_s;
        end else begin
            grant_mask_s = '0;
            evt_id_s     = evt_id_r;
        end
        if (xfer_s) begin
            last_id_s = evt_id_r;
        end else begin
            last_id_s = last_id_r;
        end

        // A grant and a new edge on the same channel leave the event pending without overflow.
        pend_s    = (pend_r & ~grant_mask_s) | rise_s;
        ovf_set_s = rise_s & pend_r & ~grant_mask_s;
        if (ovf_clr) begin
            ovf_s = ovf_set_s;
        end else begin
            ovf_s = ovf_r | ovf_set_s;
        end
    end

    // All state registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r        <= '0;
            s2_r        <= '0;
            s3_r        <= '0;
            pend_r      <= '0;
            ovf_r       <= '0;
            prime_r     <= 2'd0;
            last_id_r   <= ID_W'(N - 1);
            evt_id_r    <= '0;
            evt_valid_r <= 1'b0;
            state_r     <= IDLE;
        end else begin
            s1_r        <= async_in;
            s2_r        <= s1_r;
            s3_r        <= s2_r;
            pend_r      <= pend_s;
            ovf_r       <= ovf_s;
            prime_r     <= prime_s;
            last_id_r   <= last_id_s;
            evt_id_r    <= evt_id_s;
            evt_valid_r <= (state_s == OFFER);
            state_r     <= state_s;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_id    = evt_id_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_async_event_arbiter.sv
// Directed bench for async_event_arbiter: latency, round-robin order, overflow,
// reset priming and reset during an offer.
module tb_async_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] async_in;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] ovf;

    int checks = 0;
    int errors = 0;

    async_event_arbiter #(.N(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        async_in  = 4'b0000;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) step();
        check("rst_valid", {7'd0, evt_valid}, 8'd0);
        check("rst_id",    {6'd0, evt_id},    8'd0);
        check("rst_ovf",   {4'd0, ovf},       8'd0);
        rst = 1'b0;
        repeat (4) step();

        // Single event latency: valid exactly at E4 for one cycle.
        evt_ready = 1'b1;
        async_in  = 4'b0001;
        repeat (3) step();
        check("lat_e3_valid", {7'd0, evt_valid}, 8'd0);
        step();
        check("lat_e4_valid", {7'd0, evt_valid}, 8'd1);
        check("lat_e4_id",    {6'd0, evt_id},    8'd0);
        step();
        check("lat_e5_valid", {7'd0, evt_valid}, 8'd0);
        async_in = 4'b0000;
        repeat (4) step();

        // All four together from reset priority: 0,1,2,3 back to back.
        do_reset();
        async_in = 4'b1111;
        repeat (4) step();
        check("all_v0", {7'd0, evt_valid}, 8'd1);
        check("all_id0", {6'd0, evt_id}, 8'd0);
        step();
        check("all_v1", {7'd0, evt_valid}, 8'd1);
        check("all_id1", {6'd0, evt_id}, 8'd1);
        step();
        check("all_v2", {7'd0, evt_valid}, 8'd1);
        check("all_id2", {6'd0, evt_id}, 8'd2);
        step();
        check("all_v3", {7'd0, evt_valid}, 8'd1);
        check("all_id3", {6'd0, evt_id}, 8'd3);
        step();
        check("all_done", {7'd0, evt_valid}, 8'd0);
        check("all_ovf", {4'd0, ovf}, 8'd0);
        async_in = 4'b0000;
        repeat (4) step();

        // Wrap: channel 3 offered and held, then 0 and 3 pending -> 0 before 3.
        evt_ready = 1'b0;
        async_in  = 4'b1000;
        repeat (4) step();
        check("wrap_v3", {7'd0, evt_valid}, 8'd1);
        check("wrap_id3", {6'd0, evt_id}, 8'd3);
        async_in = 4'b0000;
        repeat (3) step();
        async_in = 4'b1001;
        repeat (3) step();
        check("wrap_hold_id", {6'd0, evt_id}, 8'd3);
        check("wrap_ovf", {4'd0, ovf}, 8'd0);
        evt_ready = 1'b1;
        step();
        check("wrap_first_v", {7'd0, evt_valid}, 8'd1);
        check("wrap_first_id", {6'd0, evt_id}, 8'd0);
        step();
        check("wrap_second_id", {6'd0, evt_id}, 8'd3);
        step();
        check("wrap_idle", {7'd0, evt_valid}, 8'd0);
        async_in = 4'b0000;
        repeat (4) step();

        // Stall on channel 2, two further edges -> overflow, then clear.
        evt_ready = 1'b0;
        async_in  = 4'b0100;
        repeat (4) step();
        check("ovf_offer_v", {7'd0, evt_valid}, 8'd1);
        check("ovf_offer_id", {6'd0, evt_id}, 8'd2);
        async_in = 4'b0000;
        repeat (3) step();
        async_in = 4'b0100;
        repeat (3) step();
        check("ovf_after_1", {4'd0, ovf}, 8'd0);
        async_in = 4'b0000;
        repeat (3) step();
        async_in = 4'b0100;
        repeat (3) step();
        check("ovf_after_2", {4'd0, ovf}, 8'h04);
        check("ovf_hold_id", {6'd0, evt_id}, 8'd2);
        check("ovf_hold_v", {7'd0, evt_valid}, 8'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", {4'd0, ovf}, 8'd0);
        evt_ready = 1'b1;
        step();
        check("ovf_requeue_v", {7'd0, evt_valid}, 8'd1);
        check("ovf_requeue_id", {6'd0, evt_id}, 8'd2);
        step();
        check("ovf_drain", {7'd0, evt_valid}, 8'd0);
        async_in = 4'b0000;
        repeat (4) step();

        // Reset pulse during an offer of channel 1 with channel 2 still pending.
        evt_ready = 1'b0;
        async_in  = 4'b0110;
        repeat (4) step();
        check("rsto_v", {7'd0, evt_valid}, 8'd1);
        check("rsto_id", {6'd0, evt_id}, 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rsto_after_v", {7'd0, evt_valid}, 8'd0);
        check("rsto_after_id", {6'd0, evt_id}, 8'd0);
        check("rsto_after_ovf", {4'd0, ovf}, 8'd0);
        evt_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen = seen | evt_valid;
        end
        check("rsto_no_pend", {7'd0, seen}, 8'd0);
        async_in = 4'b0000;
        repeat (4) step();

        // Channel 1 held high through reset: no event, then a fresh edge works.
        async_in = 4'b0010;
        rst      = 1'b1;
        repeat (2) step();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 22; i++) begin
            step();
            seen = seen | evt_valid;
        end
        check("held_no_evt", {7'd0, seen}, 8'd0);
        async_in = 4'b0000;
        repeat (3) step();
        async_in = 4'b0010;
        repeat (4) step();
        check("held_fresh_v", {7'd0, evt_valid}, 8'd1);
        check("held_fresh_id", {6'd0, evt_id}, 8'd1);
        step();
        check("held_fresh_end", {7'd0, evt_valid}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
